// File: rtl/div_if.sv
// div_if: handshake/bus bundle between the EX stage and the divider.
//   master : EX side. Drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i.
//   slave  : divider side. Drives result_o ({remainder, quotient}) and ready_o.
// Optional macro DIV_ZERO_FLAG_EN adds divzero_o (divider -> EX).
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic                  divzero_o;
`endif

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
    input  divzero_o,
`endif
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
    output divzero_o,
`endif
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for DIV/DIVU (one quotient bit
// per clock). Signed operands are divided as magnitudes and the signs are
// restored once the last iteration is done.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - div_if.slave: signed_div_i, opdata1_i (dividend), opdata2_i
//          (divisor), start_i (level-held request), annul_i (flush),
//          result_o = {remainder, quotient}, ready_o (result valid)
// Optional macro DIV_ZERO_FLAG_EN: adds bus.divzero_o, raised with ready_o
// when the completed request had a zero divisor.
module div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;       // partial remainder
  logic [DATA_W-1:0]     quo_q, quo_d;       // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]     dsr_q, dsr_d;       // divisor magnitude
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
  logic                  zero_pend_q, zero_pend_d;
  logic                  divzero_q, divzero_d;
`endif

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W:0]       shifted;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign op2_abs = op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

  // The remainder stays below the divisor, so the shifted value is below
  // twice the divisor and bit DATA_W of the difference is a true borrow.
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  // 0x80000000 / -1 lands here as magnitude 0x80000000, whose negation is
  // itself, so the overflow case needs no special handling.
  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DivFree;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      ready_q     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      zero_pend_q <= 1'b0;
      divzero_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      ready_q     <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
      zero_pend_q <= zero_pend_d;
      divzero_q   <= divzero_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    ready_d     = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    zero_pend_d = zero_pend_q;
    divzero_d   = divzero_q;
`endif

    case (state_q)
      DivFree: begin
        // annul wins over start: a flush cycle never launches a division.
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
`ifdef DIV_ZERO_FLAG_EN
            zero_pend_d = 1'b1;
`endif
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = op1_abs;
            dsr_d     = op2_abs;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
`ifdef DIV_ZERO_FLAG_EN
            zero_pend_d = 1'b0;
`endif
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
      end

      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = DivEnd;
          cnt_d    = '0;
        end else begin
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shifted[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DivEnd: begin
        if (!bus.start_i) begin
          state_d  = DivFree;
          ready_d  = 1'b0;
          result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
          divzero_d   = 1'b0;
          zero_pend_d = 1'b0;
`endif
        end else begin
          // Divide-by-zero arrives here with ready still low; raise it now.
          ready_d = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          divzero_d = zero_pend_q;
`endif
        end
      end

      default: state_d = DivFree;
    endcase
  end

  assign bus.result_o  = result_q;
  assign bus.ready_o   = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.divzero_o = divzero_q;
`endif

endmodule

// File: tb/tb_div.sv
module tb_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_if #(.DATA_W(32)) bus ();
  div #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic ready_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a new result is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ready_o && !ready_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", bus.result_o, mon_exp);
          $display("txn result=%h expected=%h", bus.result_o, mon_exp);
        end
      end
      if (!bus.ready_o) check("result_zero_when_idle", bus.result_o, 64'd0);
    end
    ready_prev = bus.ready_o;
  end

  // Waits for ready_o (bounded), checking latency counted from E0 (the first edge).
  task automatic wait_ready(input string name, input int exp_lat, input bit zero);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.opdata1_i = 32'h1234_5678;
        bus.opdata2_i = 32'h0000_0003;
      end
      if (bus.ready_o) got = 1'b1;
    end
    check({name, "_latency"}, 64'(n - 1), 64'(exp_lat));
`ifdef DIV_ZERO_FLAG_EN
    check({name, "_divzero"}, 64'(bus.divzero_o), 64'(zero));
`else
    if (zero) $display("%s: divide by zero, flag not built", name);
`endif
  endtask

  task automatic drop_start(input string name);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_ready_clear"}, 64'(bus.ready_o), 64'd0);
    check({name, "_result_clear"}, bus.result_o, 64'd0);
  endtask

  task automatic run(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int exp_lat, input int hold, input bit zero);
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    exp_q.push_back(exp);
    wait_ready(name, exp_lat, zero);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
      check({name, "_hold_result"}, bus.result_o, exp);
    end
    drop_start(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("u100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 0, 1'b0);
    run("s_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b0);
    run("s_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0, 1'b0);
    run("s_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 0, 1'b0);
    run("s_m100_7",  1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 33, 0, 1'b0);
    run("u_big",     1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   64'h00000001_00000001, 33, 0, 1'b0);
    run("u_div0",    1'b0, 32'd55,         32'd0,          64'h00000000_00000000, 2,  0, 1'b1);
    run("s_div0",    1'b1, 32'hFFFFFFF0,   32'd0,          64'h00000000_00000000, 2,  1, 1'b1);
    run("u_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 5, 1'b0);

    // Annul at iteration 10, then a fresh 20/3 on the next cycle.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("annul_pre_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.opdata1_i = 32'd20;
    bus.opdata2_i = 32'd3;
    exp_q.push_back(64'h00000002_00000006);
    wait_ready("after_annul", 33, 1'b0);
    drop_start("after_annul");

    // annul and start together in DivFree: no start that cycle.
    @(negedge clk);
    bus.opdata1_i = 32'd20;
    bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    exp_q.push_back(64'h00000002_00000006);
    @(posedge clk);
    #1;
    check("annul_prio_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.opdata1_i = 32'd20;
    bus.opdata2_i = 32'd3;
    wait_ready("annul_prio", 33, 1'b0);
    drop_start("annul_prio");

    // Reset at iteration 15, then 9/3.
    @(negedge clk);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    exp_q.push_back(64'h00000000_00000003);
    wait_ready("after_rst", 33, 1'b0);
    drop_start("after_rst");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
